// File: rtl/draw_scheduler.sv
// Draw-command queue and copy-engine sequencer (IDLE/DISPATCH/RUN/RELEASE).
// Define DRAW_SCHEDULER_CLIP_EN to drop off-screen rectangles and count them.
module draw_scheduler #(
  parameter int SrcAddrWidth = 19,
  parameter int Depth        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9:0]              cmd_x,
  input  logic [9:0]              cmd_y,
  input  logic [9:0]              cmd_w,
  input  logic [9:0]              cmd_h,
  input  logic [SrcAddrWidth-1:0] cmd_src,
  input  logic                    flush,
  output logic [9:0]              ce_dest_x_start,
  output logic [9:0]              ce_dest_x_end,
  output logic [9:0]              ce_dest_y_start,
  output logic [9:0]              ce_dest_y_end,
  output logic [SrcAddrWidth-1:0] ce_src_addr_start,
  output logic                    ce_execute,
  input  logic                    ce_status,
  output logic                    busy,
  output logic [$clog2(Depth):0]  queue_count,
  output logic [15:0]             done_count
`ifdef DRAW_SCHEDULER_CLIP_EN
  ,
  output logic [15:0]             dropped_count
`endif
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FullCount = (AW+1)'(Depth);

  typedef struct packed {
    logic [9:0]              x;
    logic [9:0]              y;
    logic [9:0]              w;
    logic [9:0]              h;
    logic [SrcAddrWidth-1:0] src;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    RUN,
    RELEASE
  } state_t;

  cmd_t          mem [Depth];
  cmd_t          in_cmd;
  cmd_t          cur;
  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          zero_size;
  logic          drop;

  assign in_cmd = '{
    x:   cmd_x,
    y:   cmd_y,
    w:   cmd_w,
    h:   cmd_h,
    src: cmd_src
  };

  assign full      = count == FullCount;
  assign empty     = count == '0;
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state == IDLE && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // Flush empties the queue by rewinding both pointers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign zero_size = cur.w == '0 || cur.h == '0;

`ifdef DRAW_SCHEDULER_CLIP_EN
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic        clip;

  assign x_sum = {1'b0, cur.x} + {1'b0, cur.w};
  assign y_sum = {1'b0, cur.y} + {1'b0, cur.h};
  assign clip  = x_sum > 11'd640 || y_sum > 11'd480;
  assign drop  = zero_size || clip;
`else
  assign drop  = zero_size;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      ce_execute <= 1'b0;
      done_count <= '0;
`ifdef DRAW_SCHEDULER_CLIP_EN
      dropped_count <= '0;
`endif
    end else if (flush) begin
      // Early exit: an aborted draw never counts as done.
      state      <= IDLE;
      ce_execute <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            cur   <= mem[rd_ptr];
            state <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (drop) begin
            state <= IDLE;
`ifdef DRAW_SCHEDULER_CLIP_EN
            if (clip) dropped_count <= dropped_count + 16'd1;
`endif
          end else begin
            state      <= RUN;
            ce_execute <= 1'b1;
          end
        end
        RUN: begin
          if (!ce_status) begin
            state      <= RELEASE;
            ce_execute <= 1'b0;
          end
        end
        RELEASE: begin
          done_count <= done_count + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ce_dest_x_start   = cur.x;
  assign ce_dest_x_end     = cur.x + cur.w;
  assign ce_dest_y_start   = cur.y;
  assign ce_dest_y_end     = cur.y + cur.h;
  assign ce_src_addr_start = cur.src;
  assign busy              = state != IDLE || !empty;
  assign queue_count       = count;

endmodule
